branch_predictor: RTL and testbench

//  Dynamic branch predictor + mispredict resolver. Fetch side: picks next_pc for if_pc from a

---
 rtl/branch_predictor_if.sv | 27 ++
 rtl/branch_predictor.sv | 115 +++++++++++
 tb/tb_branch_predictor.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/execute bundle between the pipeline and the branch predictor.
// The pipeline drives through the master modport; the predictor uses the slave modport.
interface branch_predictor_if;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] next_pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_pc;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   modport master (
      output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_pc,
      input  pred_taken, next_pc, mispredict, redirect_pc, stat_branches, stat_mispredicts
   );

   modport slave (
      input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_pc,
      output pred_taken, next_pc, mispredict, redirect_pc, stat_branches, stat_mispredicts
   );
endinterface

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: tagged direct-mapped BTB plus 2-bit BHT for fetch,
// mispredict detection, table training and statistics for resolved branches.
module branch_predictor #(
   parameter int ENTRIES = 64
) (
   input logic               clk,
   input logic               rst,
   branch_predictor_if.slave bp
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_state_e;

   bht_state_e         bht_q        [ENTRIES];
   bht_state_e         bht_d        [ENTRIES];
   logic [ENTRIES-1:0] btb_valid_q, btb_valid_d;
   logic [TAG_W-1:0]   btb_tag_q    [ENTRIES];
   logic [TAG_W-1:0]   btb_tag_d    [ENTRIES];
   logic [31:0]        btb_target_q [ENTRIES];
   logic [31:0]        btb_target_d [ENTRIES];
   logic [31:0]        stat_branches_q, stat_branches_d;
   logic [31:0]        stat_mispredicts_q, stat_mispredicts_d;

   logic [IDX_W-1:0] lidx, uidx;
   logic [TAG_W-1:0] ltag, utag;
   logic             hit;
   logic             pred_taken;
   logic [31:0]      actual_pc;
   logic             mispredict;
   logic             unused_bits;

   assign lidx = bp.if_pc[IDX_W+1:2];
   assign ltag = bp.if_pc[31:IDX_W+2];
   assign uidx = bp.upd_pc[IDX_W+1:2];
   assign utag = bp.upd_pc[31:IDX_W+2];

   // Word alignment makes pc[1:0] irrelevant; upd_pred_taken travels with the branch but is not consumed here.
   assign unused_bits = ^{bp.if_pc[1:0], bp.upd_pc[1:0], bp.upd_pred_taken};

   // Lookup reads only the registered tables, so a same-cycle update is seen one cycle later.
   always_comb begin
      hit        = btb_valid_q[lidx] && (btb_tag_q[lidx] == ltag);
      pred_taken = hit && (bht_q[lidx] inside {WT, ST});
   end

   always_comb begin
      actual_pc  = bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4;
      mispredict = bp.upd_valid && (bp.upd_pred_pc != actual_pc);
   end

   assign bp.pred_taken       = pred_taken;
   assign bp.next_pc          = pred_taken ? btb_target_q[lidx] : bp.if_pc + 32'd4;
   assign bp.mispredict       = mispredict;
   assign bp.redirect_pc      = actual_pc;
   assign bp.stat_branches    = stat_branches_q;
   assign bp.stat_mispredicts = stat_mispredicts_q;

   // NOTE: every _d gets its hold value first, so no path through this block leaves a latch.
   always_comb begin
      bht_d              = bht_q;
      btb_valid_d        = btb_valid_q;
      btb_tag_d          = btb_tag_q;
      btb_target_d       = btb_target_q;
      stat_branches_d    = stat_branches_q;
      stat_mispredicts_d = stat_mispredicts_q;

      if (bp.upd_valid) begin
         if (bp.upd_taken) begin
            case (bht_q[uidx])
               SNT:     bht_d[uidx] = WNT;
               WNT:     bht_d[uidx] = WT;
               default: bht_d[uidx] = ST;
            endcase
            btb_valid_d[uidx]  = 1'b1;
            btb_tag_d[uidx]    = utag;
            btb_target_d[uidx] = bp.upd_target;
         end else begin
            case (bht_q[uidx])
               ST:      bht_d[uidx] = WT;
               WT:      bht_d[uidx] = WNT;
               default: bht_d[uidx] = SNT;
            endcase
         end
         stat_branches_d    = stat_branches_q + 32'd1;
         stat_mispredicts_d = stat_mispredicts_q + {31'd0, mispredict};
      end
   end

   // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) bht_q[i] <= WNT;
         btb_valid_q        <= '0;
         stat_branches_q    <= '0;
         stat_mispredicts_q <= '0;
      end else begin
         bht_q              <= bht_d;
         btb_valid_q        <= btb_valid_d;
         stat_branches_q    <= stat_branches_d;
         stat_mispredicts_q <= stat_mispredicts_d;
      end
   end

   // NOTE: tag/target storage has no reset; btb_valid_q masks whatever it holds after reset.
   always_ff @(posedge clk) begin
      btb_tag_q    <= btb_tag_d;
      btb_target_q <= btb_target_d;
   end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: lookup, training, saturation, aliasing,
// same-cycle visibility, wrong-target mispredicts and asynchronous reset.
module tb_branch_predictor;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   branch_predictor_if bp ();

   branch_predictor #(.ENTRIES(64)) dut (
      .clk (clk),
      .rst (rst),
      .bp  (bp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Present one resolved branch on the execute side just after a falling edge.
   task automatic drive_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                            input logic ptaken, input logic [31:0] ppc);
      @(negedge clk);
      bp.upd_valid      = 1'b1;
      bp.upd_pc         = pc;
      bp.upd_taken      = taken;
      bp.upd_target     = tgt;
      bp.upd_pred_taken = ptaken;
      bp.upd_pred_pc    = ppc;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      bp.upd_valid = 1'b0;
   endtask

   task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_taken,
                         input logic [31:0] exp_next);
      bp.if_pc = pc;
      #1;
      check({tag, "_taken"}, {31'd0, bp.pred_taken}, {31'd0, exp_taken});
      check({tag, "_next"}, bp.next_pc, exp_next);
   endtask

   task automatic stats(input string tag, input int br, input int mp);
      check({tag, "_branches"}, bp.stat_branches, br);
      check({tag, "_mispredicts"}, bp.stat_mispredicts, mp);
   endtask

   initial begin
      bp.if_pc          = 32'h100;
      bp.upd_valid      = 1'b0;
      bp.upd_pc         = 32'h0;
      bp.upd_taken      = 1'b0;
      bp.upd_target     = 32'h0;
      bp.upd_pred_taken = 1'b0;
      bp.upd_pred_pc    = 32'h4;

      // Reset state, then after release
      #3;
      lookup("rst", 32'h100, 1'b0, 32'h104);
      stats("rst", 0, 0);
      check("rst_mispredict", {31'd0, bp.mispredict}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      lookup("post_rst", 32'h100, 1'b0, 32'h104);

      // First taken branch at 0x100: predicted fall-through, so mispredict
      drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      check("t2_mispredict", {31'd0, bp.mispredict}, 32'd1);
      check("t2_redirect", bp.redirect_pc, 32'h80);
      tick();
      lookup("t2", 32'h100, 1'b1, 32'h80);
      stats("t2", 1, 1);

      // Four more taken (correctly predicted) saturate the counter at ST
      for (int i = 0; i < 4; i++) begin
         drive_upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
         check("t3_correct", {31'd0, bp.mispredict}, 32'd0);
         tick();
      end
      lookup("t3_sat", 32'h100, 1'b1, 32'h80);
      stats("t3_sat", 5, 1);
      drive_upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
      check("t3_nt1_mispredict", {31'd0, bp.mispredict}, 32'd1);
      check("t3_nt1_redirect", bp.redirect_pc, 32'h104);
      tick();
      lookup("t3_nt1", 32'h100, 1'b1, 32'h80);
      drive_upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
      tick();
      lookup("t3_nt2", 32'h100, 1'b0, 32'h104);
      stats("t3_nt2", 7, 3);

      // Aliasing: 0x200 shares index 0 with 0x100 but has a different tag
      drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      tick();
      lookup("t4_trained", 32'h100, 1'b1, 32'h80);
      lookup("t4_alias_miss", 32'h200, 1'b0, 32'h204);
      drive_upd(32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
      tick();
      lookup("t4_evicted", 32'h100, 1'b0, 32'h104);
      lookup("t4_new", 32'h200, 1'b1, 32'h300);
      stats("t4", 9, 5);

      // Same-cycle lookup and update on a fresh entry: no bypass
      bp.if_pc = 32'h340;
      drive_upd(32'h340, 1'b1, 32'h400, 1'b0, 32'h344);
      check("t5_same_taken", {31'd0, bp.pred_taken}, 32'd0);
      check("t5_same_next", bp.next_pc, 32'h344);
      tick();
      lookup("t5_next", 32'h340, 1'b1, 32'h400);

      // Taken with the wrong predicted target
      drive_upd(32'h340, 1'b1, 32'h90, 1'b1, 32'h80);
      check("t6_wrong_tgt_mispredict", {31'd0, bp.mispredict}, 32'd1);
      check("t6_wrong_tgt_redirect", bp.redirect_pc, 32'h90);
      tick();
      lookup("t6_retarget", 32'h340, 1'b1, 32'h90);
      stats("t6", 11, 7);

      // upd_valid low: no mispredict, no training, no stat change
      @(negedge clk);
      bp.upd_pc      = 32'h500;
      bp.upd_taken   = 1'b1;
      bp.upd_target  = 32'h600;
      bp.upd_pred_pc = 32'h504;
      #1;
      check("idle_mispredict", {31'd0, bp.mispredict}, 32'd0);
      tick();
      lookup("idle_no_train", 32'h500, 1'b0, 32'h504);
      stats("idle", 11, 7);

      // Asynchronous reset mid-stream, with an update held across a reset edge
      bp.if_pc = 32'h340;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_taken", {31'd0, bp.pred_taken}, 32'd0);
      check("arst_next", bp.next_pc, 32'h344);
      stats("arst", 0, 0);
      bp.upd_valid   = 1'b1;
      bp.upd_pc      = 32'h500;
      bp.upd_taken   = 1'b1;
      bp.upd_target  = 32'h600;
      bp.upd_pred_pc = 32'h504;
      tick();
      @(negedge clk);
      rst = 1'b0;
      lookup("arst_no_train", 32'h500, 1'b0, 32'h504);
      lookup("arst_cleared", 32'h340, 1'b0, 32'h344);
      stats("arst_release", 0, 0);

      // Training works again after reset
      drive_upd(32'h340, 1'b1, 32'h90, 1'b0, 32'h344);
      tick();
      lookup("retrain", 32'h340, 1'b1, 32'h90);
      stats("retrain", 1, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
